// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder: AHB-Lite subordinate backed by an internal word array.
// Address/data-phase pipelined transfers with byte-lane writes and programmable
// wait states. Illegal transfers get the two-cycle ERROR response.
// Optional feature macro: AHB_SRAM_MISALIGN_ERR_EN -- when defined, a misaligned
// HALFWORD/WORD access is treated as illegal; when undefined it is aligned down.

package ahb_types_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} transfer_t;
  typedef enum logic [2:0] {BYTE = 3'b000, HALFWORD = 3'b001, WORD = 3'b010, WORDX2 = 3'b011,
                            WORDX4 = 3'b100, WORDX8 = 3'b101, WORDX16 = 3'b110, WORDX32 = 3'b111} size_t;
  typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} burst_t;
  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} resp_t;
endpackage

module ahb_sram_responder
  import ahb_types_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = 4;
  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]      WAIT_LOAD = CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t                 state_reg;
  logic                   hreadyout_reg;
  resp_t                  hresp_reg;
  logic                   pend_reg;       // a legal data phase is in flight
  logic [CNT_W-1:0]       wait_cnt_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [1:0]             offs_reg;
  logic                   write_reg;
  size_t                  size_reg;
  logic [DATA_WIDTH-1:0]  hrdata_reg;     // last returned read data, held between reads

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  size_t                  hsize_t;
  logic                   accept;
  logic                   out_of_range;
  logic                   bad_size;
  logic                   misaligned;
  logic                   illegal;
  logic                   complete;
  logic [LANES-1:0]       lane_en;

  // Burst type and the SEQ/NONSEQ distinction do not affect this responder.
  wire unused_ok = &{1'b0, HTRANS[0], HBURST};

  assign hsize_t = size_t'(HSIZE);

  // Only sample an address phase while our own data phase is able to finish.
  assign accept       = HSEL && HREADY && HTRANS[1] && hreadyout_reg;
  assign out_of_range = (HADDR >> 2) >= DEPTH_A;
  assign bad_size     = (hsize_t > WORD);

`ifdef AHB_SRAM_MISALIGN_ERR_EN
  assign misaligned = ((hsize_t == HALFWORD) && HADDR[0]) ||
                      ((hsize_t == WORD) && (HADDR[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign illegal  = out_of_range || bad_size || misaligned;
  assign complete = (state_reg == ST_IDLE) && pend_reg;

  // Little-endian lane enables; low address bits below the access size are ignored.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_en[gi] = (size_reg == BYTE)     ? (offs_reg == LANE) :
                           (size_reg == HALFWORD) ? (offs_reg[1] == LANE[1]) :
                                                    1'b1;
    end
  endgenerate

  // Read data is visible combinationally in the completing cycle, otherwise held.
  assign HRDATA    = (complete && !write_reg) ? mem[idx_reg] : hrdata_reg;
  assign HREADYOUT = hreadyout_reg;
  assign HRESP     = hresp_reg;

  // Commit enabled write lanes on the completing edge of a legal write.
  always_ff @(posedge HCLK) begin
    if (complete && write_reg) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          mem[idx_reg][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Transfer FSM: address capture, wait counting, two-cycle error, registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= ST_IDLE;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= OKAY;
      pend_reg      <= 1'b0;
      wait_cnt_reg  <= '0;
      idx_reg       <= '0;
      offs_reg      <= '0;
      write_reg     <= 1'b0;
      size_reg      <= BYTE;
      hrdata_reg    <= '0;
    end else begin
      if (complete && !write_reg) begin
        hrdata_reg <= mem[idx_reg];
      end
      unique case (state_reg)
        ST_IDLE, ST_ERR2: begin
          if (accept) begin
            idx_reg   <= HADDR[IDX_W+1:2];
            offs_reg  <= HADDR[1:0];
            write_reg <= HWRITE;
            size_reg  <= hsize_t;
            if (illegal) begin
              state_reg     <= ST_ERR1;
              hreadyout_reg <= 1'b0;
              hresp_reg     <= ERROR;
              pend_reg      <= 1'b0;
            end else if (WAIT_STATES > 0) begin
              state_reg     <= ST_WAIT;
              hreadyout_reg <= 1'b0;
              hresp_reg     <= OKAY;
              pend_reg      <= 1'b1;
              wait_cnt_reg  <= WAIT_LOAD;
            end else begin
              state_reg     <= ST_IDLE;
              hreadyout_reg <= 1'b1;
              hresp_reg     <= OKAY;
              pend_reg      <= 1'b1;
            end
          end else begin
            state_reg     <= ST_IDLE;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= OKAY;
            pend_reg      <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg     <= ST_IDLE;
            hreadyout_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        ST_ERR1: begin
          state_reg     <= ST_ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= ERROR;
        end
        default: begin
          state_reg     <= ST_IDLE;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= OKAY;
          pend_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Bench for ahb_sram_responder: two instances (0 and 2 wait states) driven by a
// simple master; expected responses are queued at drive time and popped when
// each data phase completes. Honours AHB_SRAM_MISALIGN_ERR_EN like the design.
module tb_ahb_sram_responder;
  import ahb_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [31:0] hwdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  ahb_sram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
    .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_sram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) dut2 (
    .HCLK(clk), .HRESETn(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
    .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  typedef struct {
    string       tag;
    bit          err;
    bit          rd;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem    [2][1024];
  logic [31:0] last_rdata [2];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_illegal(input logic [31:0] a, input logic [2:0] s);
    bit bad;
    bad = ((a >> 2) >= 32'd1024) || (s > 3'd2);
`ifdef AHB_SRAM_MISALIGN_ERR_EN
    if (s == 3'd1 && a[0]) bad = 1'b1;
    if (s == 3'd2 && a[1:0] != 2'b00) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [31:0] a, input logic [2:0] s);
    logic [3:0] m;
    case (s)
      3'd0:    m = 4'b0001 << a[1:0];
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Wait for the data phase of the oldest queued transfer and compare it.
  task automatic collect(input int d);
    exp_t e;
    int   lows;
    bit   done;
    e    = sb.pop_front();
    lows = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (hreadyout[d]) begin
        check_val({e.tag, " hresp"}, {31'b0, hresp[d]}, {31'b0, e.err});
        check_val({e.tag, " waits"}, lows, e.waits);
        if (e.rd || e.err) check_val({e.tag, " hrdata"}, hrdata[d], e.rdata);
        done = 1'b1;
      end else begin
        check_val({e.tag, " stall hresp"}, {31'b0, hresp[d]}, {31'b0, e.err});
        lows++;
      end
    end
    check_val({e.tag, " done"}, {31'b0, done}, 32'd1);
    $display("xfer %s dut%0d err=%0d waits=%0d rdata=%h", e.tag, d, e.err, lows, hrdata[d]);
    @(posedge clk); #1;
  endtask

  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] wd, input string tag);
    exp_t       e;
    logic [3:0] m;
    e.tag   = tag;
    e.err   = is_illegal(a, s);
    e.rd    = !wr;
    e.waits = e.err ? 1 : ((d == 0) ? 0 : 2);
    e.rdata = last_rdata[d];
    if (!e.err) begin
      if (wr) begin
        m = lane_mask(a, s);
        for (int l = 0; l < 4; l++) if (m[l]) ref_mem[d][a[11:2]][8*l +: 8] = wd[8*l +: 8];
      end else begin
        e.rdata       = ref_mem[d][a[11:2]];
        last_rdata[d] = e.rdata;
      end
    end
    sb.push_back(e);
    hsel[d] = 1'b1; htrans[d] = NONSEQ; haddr[d] = a; hwrite[d] = wr; hsize[d] = s;
    @(posedge clk); #1;
    hsel[d] = 1'b0; htrans[d] = IDLE; hwdata[d] = wd;
    collect(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = IDLE; hwrite[d] = 1'b0;
      hsize[d] = WORD; hburst[d] = '0; hwdata[d] = '0; last_rdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_val("reset hreadyout", {31'b0, hreadyout[d]}, 32'd1);
      check_val("reset hresp", {31'b0, hresp[d]}, 32'd0);
      check_val("reset hrdata", hrdata[d], 32'd0);
      rst_n[d] = 1'b1;
    end
    @(posedge clk); #1;

    // Basic word write/read, then byte and halfword lanes.
    xfer(0, 1, 32'h10, WORD, 32'hDEADBEEF, "wr_word_10");
    xfer(0, 0, 32'h10, WORD, 32'h0, "rd_word_10");
    check_val("spec deadbeef", last_rdata[0], 32'hDEADBEEF);
    xfer(0, 1, 32'h13, BYTE, 32'hAB000000, "wr_byte_13");
    xfer(0, 0, 32'h10, WORD, 32'h0, "rd_after_byte");
    check_val("spec abadbeef", last_rdata[0], 32'hABADBEEF);
    xfer(0, 1, 32'h14, WORD, 32'h00000000, "wr_word_14");
    xfer(0, 1, 32'h16, HALFWORD, 32'hBEEF0000, "wr_half_16");
    xfer(0, 1, 32'h15, BYTE, 32'h0000CC00, "wr_byte_15");
    xfer(0, 0, 32'h14, WORD, 32'h0, "rd_word_14");

    // Wait-state instance.
    xfer(1, 1, 32'h0, WORD, 32'hA5A5A5A5, "ws_wr_0");
    xfer(1, 0, 32'h0, WORD, 32'h0, "ws_rd_0");

    // Illegal transfers leave memory untouched and hold HRDATA.
    xfer(0, 1, 32'h0, WORD, 32'h0BADF00D, "wr_word_0");
    xfer(0, 1, 32'h1000, WORD, 32'hFFFFFFFF, "err_wr_range");
    xfer(0, 0, 32'h0, WORD, 32'h0, "rd_after_range");
    xfer(0, 1, 32'h0, WORDX2, 32'hFFFFFFFF, "err_wr_size");
    xfer(0, 0, 32'h0, WORD, 32'h0, "rd_after_size");
    xfer(0, 0, 32'h1000, WORD, 32'h0, "err_rd_range");
    xfer(0, 1, 32'hFFC, WORD, 32'h77778888, "wr_top_word");
    xfer(0, 0, 32'hFFC, WORD, 32'h0, "rd_top_word");
    xfer(1, 1, 32'h1000, WORD, 32'h12121212, "ws_err_range");
    xfer(1, 0, 32'h0, WORD, 32'h0, "ws_rd_after_err");

    // Misaligned word access.
    xfer(0, 1, 32'h0, WORD, 32'h12345678, "wr_word_0b");
    xfer(0, 1, 32'h2, WORD, 32'hCAFEF00D, "wr_word_misal");
    xfer(0, 0, 32'h0, WORD, 32'h0, "rd_after_misal");

    // Reset while a write sits in its wait states.
    xfer(1, 1, 32'h20, WORD, 32'h11112222, "ws_wr_20");
    hsel[1] = 1'b1; htrans[1] = NONSEQ; haddr[1] = 32'h20; hwrite[1] = 1'b1; hsize[1] = WORD;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = IDLE; hwdata[1] = 32'h33334444;
    @(negedge clk);
    check_val("rst pre hreadyout", {31'b0, hreadyout[1]}, 32'd0);
    rst_n[1] = 1'b0;
    #1;
    check_val("rst hreadyout", {31'b0, hreadyout[1]}, 32'd1);
    check_val("rst hresp", {31'b0, hresp[1]}, 32'd0);
    check_val("rst hrdata", hrdata[1], 32'd0);
    $display("xfer rst_in_wait dut1 hreadyout=%0d hresp=%0d", hreadyout[1], hresp[1]);
    last_rdata[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    xfer(1, 0, 32'h20, WORD, 32'h0, "ws_rd_20_old");

    // Back-to-back write then read of the same word.
    hsel[0] = 1'b1; htrans[0] = NONSEQ; haddr[0] = 32'h40; hwrite[0] = 1'b1; hsize[0] = WORD;
    @(posedge clk); #1;
    hwdata[0] = 32'h5A5A1234; hwrite[0] = 1'b0;
    @(negedge clk);
    check_val("b2b wr hreadyout", {31'b0, hreadyout[0]}, 32'd1);
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans[0] = IDLE;
    ref_mem[0][16] = 32'h5A5A1234;
    last_rdata[0]  = ref_mem[0][16];
    @(negedge clk);
    check_val("b2b rd hreadyout", {31'b0, hreadyout[0]}, 32'd1);
    check_val("b2b rd hresp", {31'b0, hresp[0]}, 32'd0);
    check_val("b2b rd hrdata", hrdata[0], ref_mem[0][16]);
    $display("xfer b2b_wr_rd dut0 rdata=%h", hrdata[0]);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
